// File: rtl/seqdet_rr_scheduler.sv
// One "101" overlapping Moore detector time-shared across NCH serial channels.
// A round-robin arbiter grants one channel per cycle and advances its saved state context.
module seqdet_rr_scheduler #(
  parameter int NCH  = 4,
  parameter int CNTW = 8,
  parameter int CHW  = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                areset,
  input  logic [NCH-1:0]      in_valid,
  input  logic [NCH-1:0]      in_bit,
  output logic [NCH-1:0]      in_ready,
  input  logic [NCH-1:0]      ch_clear,
  output logic                match_valid,
  output logic [CHW-1:0]      match_ch,
  output logic [NCH-1:0]      ch_out,
  output logic [NCH*CNTW-1:0] hit_cnt
);

  typedef enum logic [1:0] {
    ST_A = 2'd0,
    ST_B = 2'd1,
    ST_C = 2'd2,
    ST_D = 2'd3
  } state_t;

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  state_t          ctx [NCH];
  logic [CNTW-1:0] cnt [NCH];
  logic [CHW-1:0]  ptr;

  logic [NCH-1:0]  eligible;
  logic [CHW-1:0]  cand;
  logic            grant_any;
  logic [CHW-1:0]  grant_idx;
  state_t          grant_next;

  function automatic state_t next_state(input state_t s, input logic b);
    case (s)
      ST_A:    return b ? ST_B : ST_A;
      ST_B:    return b ? ST_B : ST_C;
      ST_C:    return b ? ST_D : ST_A;
      default: return b ? ST_B : ST_C;
    endcase
  endfunction

  // A cleared channel is never granted, and nothing is accepted while reset is held.
  assign eligible = in_valid & ~ch_clear & {NCH{~areset}};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    in_ready  = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = CHW'((int'(ptr) + k) % NCH);
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) in_ready[grant_idx] = 1'b1;
  end

  assign grant_next = next_state(ctx[grant_idx], in_bit[grant_idx]);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      // NOTE: the context and counter arrays are a handful of flops, so they take the
      // async reset directly rather than being treated as an unreset memory.
      ptr         <= CHW'(NCH - 1);
      match_valid <= 1'b0;
      match_ch    <= '0;
      for (int i = 0; i < NCH; i++) begin
        ctx[i] <= ST_A;
        cnt[i] <= '0;
      end
    end else begin
      match_valid <= 1'b0;
      if (grant_any) begin
        ptr            <= grant_idx;
        ctx[grant_idx] <= grant_next;
        if (grant_next == ST_D) begin
          match_valid <= 1'b1;
          match_ch    <= grant_idx;
          if (cnt[grant_idx] != CNT_MAX) cnt[grant_idx] <= cnt[grant_idx] + CNTW'(1);
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (ch_clear[i]) begin
          ctx[i] <= ST_A;
          cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    ch_out  = '0;
    hit_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_out[i]                 = (ctx[i] == ST_D);
      hit_cnt[i*CNTW +: CNTW]   = cnt[i];
    end
  end

endmodule

// File: tb/tb_seqdet_rr_scheduler.sv
// Bench for seqdet_rr_scheduler: directed scenarios plus random traffic against a model
// that detects "101" from each channel's last three accepted bits.
module tb_seqdet_rr_scheduler;

  localparam int NCH  = 4;
  localparam int CNTW = 3;
  localparam int CHW  = 2;
  localparam int CMAX = (1 << CNTW) - 1;

  logic                clk = 1'b0;
  logic                areset;
  logic [NCH-1:0]      in_valid, in_bit, in_ready, ch_clear, ch_out;
  logic                match_valid;
  logic [CHW-1:0]      match_ch;
  logic [NCH*CNTW-1:0] hit_cnt;

  always #5 clk = ~clk;

  seqdet_rr_scheduler #(.NCH(NCH), .CNTW(CNTW), .CHW(CHW)) dut (
    .clk(clk), .areset(areset), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .ch_clear(ch_clear), .match_valid(match_valid),
    .match_ch(match_ch), .ch_out(ch_out), .hit_cnt(hit_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: grant pointer, last three accepted bits per channel, hit counts.
  int         m_ptr;
  logic [2:0] m_hist [NCH];
  int         m_len  [NCH];
  int         m_cnt  [NCH];
  logic       m_mv;
  int         m_mch;
  int         last_grant;
  int         ch2_hits;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ptr = NCH - 1;
    m_mv  = 1'b0;
    m_mch = 0;
    for (int i = 0; i < NCH; i++) begin
      m_hist[i] = '0;
      m_len[i]  = 0;
      m_cnt[i]  = 0;
    end
  endfunction

  task automatic check_outputs();
    logic [NCH-1:0]      e_out;
    logic [NCH*CNTW-1:0] e_hit;
    for (int i = 0; i < NCH; i++) begin
      e_out[i]               = (m_len[i] >= 3) && (m_hist[i] == 3'b101);
      e_hit[i*CNTW +: CNTW]  = CNTW'(m_cnt[i]);
    end
    check("match_valid", 64'(match_valid), 64'(m_mv));
    check("match_ch", 64'(match_ch), 64'(m_mch));
    check("ch_out", 64'(ch_out), 64'(e_out));
    check("hit_cnt", 64'(hit_cnt), 64'(e_hit));
  endtask

  // Called at a falling edge: drive, check the grant, clock, update the model, check outputs.
  task automatic cycle(input logic [NCH-1:0] v, input logic [NCH-1:0] b, input logic [NCH-1:0] c);
    logic [NCH-1:0] elig, e_rdy;
    int g;
    in_valid = v;
    in_bit   = b;
    ch_clear = c;
    #1;
    elig = v & ~c;
    g    = -1;
    for (int k = 1; k <= NCH; k++) begin
      if (g < 0 && elig[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
    end
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    check("in_ready", 64'(in_ready), 64'(e_rdy));
    last_grant = g;
    @(posedge clk);
    m_mv = 1'b0;
    if (g >= 0) begin
      m_ptr     = g;
      m_hist[g] = {m_hist[g][1:0], b[g]};
      m_len[g]++;
      if (m_len[g] >= 3 && m_hist[g] == 3'b101) begin
        m_mv  = 1'b1;
        m_mch = g;
        if (m_cnt[g] < CMAX) m_cnt[g]++;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (c[i]) begin
        m_hist[i] = '0;
        m_len[i]  = 0;
        m_cnt[i]  = 0;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic reset_dut();
    areset   = 1'b1;
    in_valid = '1;
    in_bit   = '1;
    ch_clear = '0;
    #1;
    model_reset();
    check("rst_ready", 64'(in_ready), 64'(0));
    check_outputs();
    @(negedge clk);
    areset = 1'b0;
  endtask

  initial begin
    logic [4:0]     seq;
    logic [NCH-1:0] rv, rb, rc;
    int s, guard;

    // 1: channel 0 alone, bits 1,0,1.
    reset_dut();
    cycle(4'b0001, 4'b0001, '0);
    cycle(4'b0001, 4'b0000, '0);
    cycle(4'b0001, 4'b0001, '0);

    // 2: all channels valid from reset; each sees 1,0,1 across three rounds.
    reset_dut();
    for (int cyc = 0; cyc < 12; cyc++)
      cycle('1, (cyc < 4 || cyc >= 8) ? 4'b1111 : 4'b0000, '0);

    // 3: channel 2 gets 1,0,1,0,1 interleaved with zero-bit traffic on channel 1.
    cycle('0, '0, '1);
    seq      = 5'b10101;
    s        = 0;
    guard    = 0;
    ch2_hits = 0;
    while (s < 5 && guard < 40) begin
      cycle(4'b0110, {1'b0, seq[4-s], 2'b00}, '0);
      if (last_grant == 2) s++;
      if (match_valid && match_ch == 2'd2) ch2_hits++;
      guard++;
    end
    check("ch2_done", 64'(s), 64'(5));
    check("ch2_hits", 64'(ch2_hits), 64'(2));

    // 4: channel 3 reaches C, then is cleared while presenting a 1, then receives a 1.
    cycle(4'b1000, 4'b1000, '0);
    cycle(4'b1000, 4'b0000, '0);
    cycle(4'b1000, 4'b1000, 4'b1000);
    cycle(4'b1000, 4'b1000, '0);

    // 5: channel 0 fed "10" repeatedly until its counter has saturated.
    cycle('0, '0, '1);
    for (int i = 0; i < 2 * (CMAX + 2) + 1; i++)
      cycle(4'b0001, (i % 2 == 0) ? 4'b0001 : 4'b0000, '0);

    // 6: async reset mid-cycle while channel 1 sits in D with a match pulse showing.
    cycle('0, '0, '1);
    cycle(4'b0010, 4'b0010, '0);
    cycle(4'b0010, 4'b0000, '0);
    cycle(4'b0010, 4'b0010, '0);
    #2;
    areset = 1'b1;
    #1;
    model_reset();
    check("async_ready", 64'(in_ready), 64'(0));
    check_outputs();
    @(negedge clk);
    areset = 1'b0;
    cycle(4'b1110, 4'b1111, '0);
    check("first_grant", 64'(last_grant), 64'(1));

    // Random traffic with occasional clears.
    for (int n = 0; n < 1500; n++) begin
      rv = NCH'($urandom);
      rb = NCH'($urandom);
      rc = ($urandom_range(0, 7) == 0) ? NCH'(1 << $urandom_range(0, NCH - 1)) : '0;
      cycle(rv, rb, rc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seqdet_rr_scheduler.md
Name: seqdet_rr_scheduler

Overview:
- Time-multiplexes one "101" overlapping-sequence detector (Moore, states A/B/C/D, output high in D) across NCH serial input channels.
- Each channel presents one bit per valid/ready transfer.
- A round-robin arbiter grants at most one channel per cycle. The grant reads that channel's saved 2-bit state context, advances it and writes it back.
- Reports per-channel match pulses, a Moore-style level per channel, and saturating hit counters for the status block.

Parameters:
- NCH, 4, number of serial channels (2..16).
- CNTW, 8, width of each per-channel saturating hit counter.
- CHW, $clog2(NCH), width of the channel index.

Ports:
- clk  input  1  rising-edge clock
- areset  input  1  asynchronous active-high reset
- in_valid  input  NCH  per-channel bit-valid
- in_bit  input  NCH  per-channel serial bit, qualified by in_valid
- in_ready  output  NCH  one-hot grant; transfer on channel i when in_valid[i] & in_ready[i]
- ch_clear  input  NCH  synchronous per-channel context and counter clear
- match_valid  output  1  registered pulse: the transfer accepted last cycle completed "101"
- match_ch  output  CHW  channel of that match; holds its last value when match_valid=0
- ch_out  output  NCH  Moore level, ch_out[i] = (ctx[i]==D)
- hit_cnt  output  NCH*CNTW  flat bus of counters; channel i at [i*CNTW +: CNTW]

Behaviour:
- Encoding: A=0, B=1, C=2, D=3. Per-channel register ctx[i] holds the state.
- Transition per accepted bit b:
  - A: b ? B : A
  - B: b ? B : C
  - C: b ? D : A
  - D: b ? B : C
- Reset (areset high, async):
  - ctx[i]=A and hit_cnt=0 for all channels.
  - match_valid=0, match_ch=0, ch_out=0.
  - RR pointer = NCH-1, so channel 0 has first priority.
- Eligibility: channel i is eligible when in_valid[i] & ~ch_clear[i].
- Arbitration (combinational in_ready):
  - Search order starts at pointer+1 mod NCH.
  - The first eligible channel gets in_ready=1; all other bits are 0.
  - No eligible channel gives in_ready=0.
  - in_ready never asserts for a channel with in_valid=0.
- Pointer update: on a transfer the pointer loads the granted index; with no transfer it holds.
- On a transfer for channel g:
  - ctx[g] <= next(ctx[g], in_bit[g]) at the clock edge.
  - If the next state is D:
    - match_valid <= 1 and match_ch <= g, both visible the cycle after the transfer.
    - hit_cnt[g] increments and saturates at 2^CNTW-1.
  - Otherwise match_valid <= 0.
- Throughput and latency:
  - Throughput is one bit per cycle in aggregate. A single channel requesting alone is granted every cycle.
  - Latency from transfer to match_valid is 1 cycle.
  - ch_out reflects ctx after the edge.
- ch_clear[i]:
  - Next edge sets ctx[i]=A and hit_cnt[i]=0.
  - Takes priority over any transfer on channel i; that channel is not granted in that cycle.
  - Other channels are unaffected.
- Saturation: the counter stays at max on further matches; match_valid still pulses.
- Overlap: from D, input 0 goes to C and a following 1 goes back to D, so "10101" yields 2 matches.
- Async reset mid-stream: all contexts, counters and pulses clear immediately. A bit presented during reset is not accepted (in_ready=0 while areset=1).

Test Plan:
1. Reset then channel 0 only, bits 1,0,1 on consecutive cycles:
   - in_ready=0001 each cycle.
   - match_valid=1 with match_ch=0 one cycle after the third transfer.
   - ch_out[0]=1; hit_cnt ch0=1.
2. All 4 channels valid continuously from reset:
   - Grants in order 0,1,2,3,0,1…
   - Each channel receiving bits 1,0,1 matches on its third grant, at cycles 9..12; match_ch sequence is 0,1,2,3.
3. Channel 2 receives bits 1,0,1,0,1 interleaved with channel 1 traffic:
   - Exactly two matches with match_ch=2.
   - Channel 1 context is undisturbed and has no false match.
4. Channel 3 is in C (after bits 1,0); assert ch_clear[3] with in_valid[3]=1, in_bit=1:
   - No grant to channel 3; ctx[3]=A; hit_cnt ch3=0.
   - Next bit 1 gives state B with no match.
5. CNTW=2, channel 0 fed the repeating pattern "10":
   - Counter reads 1,2,3,3.
   - The 4th and 5th matches still pulse match_valid.
6. Assert areset asynchronously mid-cycle while channel 1 is in D:
   - ch_out, match_valid and counters go to 0 immediately.
   - After deassert, the first grant goes to the lowest-index eligible channel.
